alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU: WIDTH-bit operands, 8 operations, status flags, and valid/ready handshakes on input and output.
- Single-cycle ops produce a result one cycle after acceptance.
- Multiply is an iterative shift-add unit taking WIDTH cycles.
- Sits between the operand-fetch stage and the writeback stage of the datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a power of 2 and at least 4.
- SHW, $clog2(WIDTH), shift-amount width; derived, not to be overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block accepts operands this cycle.
- left  input  WIDTH  operand A.
- right  input  WIDTH  operand B; for shifts, the amount is right[SHW-1:0].
- mode  input  3  operation: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr (logical), 7 mul.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer takes the result.
- alu_out  output  WIDTH  result.
- carry  output  1  carry out (add), borrow (sub), any nonzero upper product bit (mul), last bit shifted out (shl/shr); 0 for logic ops.
- overflow  output  1  signed overflow for add/sub; 0 otherwise.
- zero  output  1  alu_out == 0.
- negative  output  1  alu_out[WIDTH-1].

Behaviour:
- Reset, asynchronous: state IDLE; out_valid, alu_out, all flags, and the multiply counter go to 0. in_ready=1 once reset deasserts.
- States are IDLE, MUL, and HOLD.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). It is combinational from state and out_ready only, never from in_valid.
- Accept: in_valid & in_ready at a rising edge. left, right, and mode are captured then; later input changes are ignored.
- Accepting a non-mul op: the result and flags are registered and the state goes to HOLD. out_valid=1 on the next cycle (latency 1).
- Accepting mul: operands are loaded into the multiplicand/multiplier/accumulator (2*WIDTH-bit accumulator) and the state goes to MUL.
- MUL state:
  - One shift-add step per cycle for WIDTH cycles; counter runs 0..WIDTH-1.
  - After the last step the state goes to HOLD, with alu_out = product[WIDTH-1:0] and carry = |product[2*WIDTH-1:WIDTH].
  - out_valid rises WIDTH+1 cycles after the accept edge.
  - in_ready=0 and out_valid=0 throughout.
- HOLD state:
  - out_valid=1; alu_out and flags stay stable until the handshake.
  - out_valid & out_ready with no new accept: state goes to IDLE and out_valid drops next cycle.
  - out_valid & out_ready with a simultaneous accept: the result is consumed and the new op is issued in the same edge. Back-to-back non-mul ops sustain 1 result/cycle.
- Shifts: an amount of 0 gives alu_out=left and carry=0. The amount is taken mod WIDTH, with no wider shifts.
- Add/sub: computed in WIDTH+1 bits. Sub carry=1 when right > left (unsigned). Overflow uses the standard sign rule.
- Reset asserted mid-MUL or in HOLD: the operation is aborted, the result is discarded, and no out_valid pulse occurs.
- No X on any output after reset, including for illegal or unused encodings.

Optional Feature:
- Macro ALU_PIPE_SAT_EN.
- Defined: add/sub saturate as signed. On overflow, alu_out = {0,1...1} for positive overflow or {1,0...0} for negative overflow. The overflow flag is still set, and carry is unchanged.
- Undefined: add/sub wrap modulo 2^WIDTH. No saturation logic is built.

Test Plan:
- Add, WIDTH=8, left=8'hF0, right=8'h20 -> alu_out=8'h10, carry=1, overflow=0, zero=0; out_valid exactly 1 cycle after accept.
- Sub, 8'h80-8'h01 -> 8'h7F, overflow=1, carry=0; 8'h05-8'h05 -> 8'h00, zero=1; 8'h03-8'h05 -> 8'hFE, carry=1, negative=1.
- Mul, 8'h0D*8'h0B -> 8'h8F, carry=0, out_valid 9 cycles after accept, in_ready=0 for cycles 1..8; 8'h10*8'h10 -> 8'h00, carry=1, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> alu_out/flags stable, in_ready=0. Then stream 4 xor ops with out_ready=1 -> 4 results on consecutive cycles in order.
- Reset mid-mul: assert reset 3 cycles after accept -> outputs 0 immediately; after release, no out_valid, in_ready=1, next add correct.
- ALU_PIPE_SAT_EN defined: 8'h7F+8'h01 -> 8'h7F, overflow=1; 8'h80-8'h01 -> 8'h80. Undefined: 8'h80 and 8'h7F respectively, overflow=1 in both builds.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: registered WIDTH-bit ALU with valid/ready handshakes on both sides.
// Single-cycle ops (add/sub/logic/shift) produce a result one cycle after accept;
// multiply is an iterative shift-add unit taking WIDTH cycles in the MUL state.
// Optional feature: define ALU_PIPE_SAT_EN to make add/sub saturate as signed.
module alu_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  // Shift-amount width; derived from WIDTH only.
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpOr  = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpShl = 3'd5;
  localparam logic [2:0] OpShr = 3'd6;
  localparam logic [2:0] OpMul = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StHold
  } state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       res_q, res_d;
  logic                   carry_q, carry_d;
  logic                   ovf_q, ovf_d;
  logic                   zero_q, zero_d;
  logic                   neg_q, neg_d;
  logic [2*WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [SHW-1:0]         cnt_q, cnt_d;

  logic                   accept;
  logic [SHW-1:0]         sh_amt;
  logic [WIDTH:0]         add_ext;
  logic [WIDTH:0]         sub_ext;
  logic [WIDTH:0]         shl_ext;
  logic [WIDTH:0]         shr_ext;
  logic [WIDTH-1:0]       op_res;
  logic                   op_carry;
  logic                   op_ovf;
  logic [2*WIDTH-1:0]     acc_step;

  // Handshake: ready depends only on state and the downstream ready.
  always_comb begin
    in_ready = (state_q == StIdle) || ((state_q == StHold) && out_ready);
    accept   = in_valid && in_ready;
  end

  // Single-cycle datapath evaluated on the live operands at the accept edge.
  always_comb begin
    sh_amt   = right[SHW-1:0];
    add_ext  = {1'b0, left} + {1'b0, right};
    sub_ext  = {1'b0, left} - {1'b0, right};
    // One guard bit on the far side of each shift catches the last bit shifted out;
    // an amount of 0 leaves the guard bit at 0.
    shl_ext  = {1'b0, left} << sh_amt;
    shr_ext  = {left, 1'b0} >> sh_amt;
    op_res   = '0;
    op_carry = 1'b0;
    op_ovf   = 1'b0;
    case (mode)
      OpAdd: begin
        op_res   = add_ext[WIDTH-1:0];
        op_carry = add_ext[WIDTH];
        op_ovf   = (left[WIDTH-1] == right[WIDTH-1]) && (add_ext[WIDTH-1] != left[WIDTH-1]);
      end
      OpSub: begin
        op_res   = sub_ext[WIDTH-1:0];
        op_carry = sub_ext[WIDTH];  // borrow: right > left unsigned
        op_ovf   = (left[WIDTH-1] != right[WIDTH-1]) && (sub_ext[WIDTH-1] != left[WIDTH-1]);
      end
      OpAnd: op_res = left & right;
      OpOr:  op_res = left | right;
      OpXor: op_res = left ^ right;
      OpShl: begin
        op_res   = shl_ext[WIDTH-1:0];
        op_carry = shl_ext[WIDTH];
      end
      OpShr: begin
        op_res   = shr_ext[WIDTH:1];
        op_carry = shr_ext[0];
      end
      default: ;  // multiply goes through the iterative unit
    endcase
`ifdef ALU_PIPE_SAT_EN
    // Signed overflow can only happen in the direction of left's sign, so it
    // alone picks the saturation rail.
    if (((mode == OpAdd) || (mode == OpSub)) && op_ovf) begin
      op_res = left[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // One shift-add step: accumulate the multiplicand when the multiplier LSB is set.
  always_comb begin
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  // Next-state logic for the control FSM, result registers and multiply unit.
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle, StHold: begin
        if (accept) begin
          if (mode == OpMul) begin
            // Old result stays in res_q but is not presented while in MUL.
            state_d  = StMul;
            mcand_d  = {{WIDTH{1'b0}}, left};
            mplier_d = right;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d = StHold;
            res_d   = op_res;
            carry_d = op_carry;
            ovf_d   = op_ovf;
            zero_d  = (op_res == '0);
            neg_d   = op_res[WIDTH-1];
          end
        end else if ((state_q == StHold) && out_ready) begin
          state_d = StIdle;
        end
      end
      StMul: begin
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        acc_d    = acc_step;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          // Last step folds straight into the result registers.
          state_d = StHold;
          cnt_d   = '0;
          res_d   = acc_step[WIDTH-1:0];
          carry_d = |acc_step[2*WIDTH-1:WIDTH];
          ovf_d   = 1'b0;
          zero_d  = (acc_step[WIDTH-1:0] == '0);
          neg_d   = acc_step[WIDTH-1];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any operation in flight and clears the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      res_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs come straight from registered state.
  always_comb begin
    out_valid = (state_q == StHold);
    alu_out   = res_q;
    carry     = carry_q;
    overflow  = ovf_q;
    zero      = zero_q;
    negative  = neg_q;
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): directed steps, scoreboard of
// expected results popped by a monitor whenever a result is handed off.
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] left;
  logic [W-1:0] right;
  logic [2:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_out;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic         negative;

  int           checks = 0;
  int           errors = 0;
  int           npop   = 0;
  logic [11:0]  sb[$];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .left      (left),
    .right     (right),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: {result, carry, overflow, zero, negative}.
  function automatic logic [11:0] model(input logic [2:0] m, input logic [7:0] a,
                                        input logic [7:0] b);
    int ua  = a;
    int ub  = b;
    int sa  = $signed(a);
    int sbv = $signed(b);
    int amt = ub % 8;
    int s;
    logic [7:0] r = 8'h00;
    logic c = 1'b0;
    logic v = 1'b0;
    case (m)
      3'd0: begin
        s = sa + sbv;
        r = 8'(ua + ub);
        c = (ua + ub) > 255;
        v = (s > 127) || (s < -128);
`ifdef ALU_PIPE_SAT_EN
        if (s > 127) r = 8'h7F;
        else if (s < -128) r = 8'h80;
`endif
      end
      3'd1: begin
        s = sa - sbv;
        r = 8'(ua - ub);
        c = ub > ua;
        v = (s > 127) || (s < -128);
`ifdef ALU_PIPE_SAT_EN
        if (s > 127) r = 8'h7F;
        else if (s < -128) r = 8'h80;
`endif
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        r = 8'(ua << amt);
        c = (amt != 0) ? 1'((ua >> (8 - amt)) & 1) : 1'b0;
      end
      3'd6: begin
        r = 8'(ua >> amt);
        c = (amt != 0) ? 1'((ua >> (amt - 1)) & 1) : 1'b0;
      end
      default: begin
        s = ua * ub;
        r = 8'(s);
        c = s > 255;
      end
    endcase
    return {r, c, v, (r == 8'h00), r[7]};
  endfunction

  // Monitor: a result is handed off when out_valid & out_ready at the next edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      chk("sb_nonempty", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        chk("result", {alu_out, carry, overflow, zero, negative}, sb.pop_front());
        npop++;
      end
    end
  end

  task automatic drive(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
    mode     = m;
    left     = a;
    right    = b;
    in_valid = 1'b1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
  endtask

  // Issue one op with out_ready=1, check latency and that in_ready stays low while busy.
  task automatic run_op(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                        input int exp_lat, input string tag);
    int   lat = 1;
    logic busy_ok = 1'b1;
    drive(m, a, b);
    wait_ready();
    sb.push_back(model(m, a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
    mode     = 3'($urandom);
    left     = 8'($urandom);
    right    = 8'($urandom);
    while (!out_valid && lat < 50) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_ready"}, busy_ok, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int   p0;
    logic seen;
    logic [11:0] bp_exp;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mode      = 3'd0;
    left      = '0;
    right     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, alu_out, carry, overflow, zero, negative}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 1);
    out_ready = 1'b1;

    // Single-cycle ops
    run_op(3'd0, 8'hF0, 8'h20, 1, "add");
    run_op(3'd1, 8'h80, 8'h01, 1, "sub_ovf");
    run_op(3'd1, 8'h05, 8'h05, 1, "sub_zero");
    run_op(3'd1, 8'h03, 8'h05, 1, "sub_borrow");
    run_op(3'd2, 8'hC3, 8'h5A, 1, "and");
    run_op(3'd3, 8'hC3, 8'h5A, 1, "or");
    run_op(3'd4, 8'hC3, 8'h5A, 1, "xor");
    run_op(3'd5, 8'h81, 8'h01, 1, "shl1");
    run_op(3'd5, 8'h81, 8'h00, 1, "shl0");
    run_op(3'd5, 8'h81, 8'h09, 1, "shl_mod");
    run_op(3'd6, 8'h81, 8'h01, 1, "shr1");
    run_op(3'd6, 8'h0C, 8'h03, 1, "shr3");
    run_op(3'd6, 8'h0C, 8'h00, 1, "shr0");

    // Multiply
    run_op(3'd7, 8'h0D, 8'h0B, 9, "mul");
    run_op(3'd7, 8'h10, 8'h10, 9, "mul_wrap");

    // Signed overflow corners (saturating or wrapping by build)
    run_op(3'd0, 8'h7F, 8'h01, 1, "add_pos_ovf");
    run_op(3'd1, 8'h80, 8'h01, 1, "sub_neg_ovf");

    // Backpressure: result must hold and in_ready stay low while out_ready=0
    p0        = npop;
    out_ready = 1'b0;
    drive(3'd0, 8'h12, 8'h34);
    wait_ready();
    sb.push_back(model(3'd0, 8'h12, 8'h34));
    bp_exp = model(3'd0, 8'h12, 8'h34);
    @(posedge clk); #1;
    drive(3'd4, 8'hA5, 8'h0F);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", {alu_out, carry, overflow, zero, negative}, bp_exp);
      @(posedge clk); #1;
    end

    // Release and stream xor ops at one per cycle
    sb.push_back(model(3'd4, 8'hA5, 8'h0F));
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k < 4; k++) begin
      drive(3'd4, 8'(8'h11 * k), 8'(8'h3C + k));
      sb.push_back(model(3'd4, 8'(8'h11 * k), 8'(8'h3C + k)));
      chk("stream_out_valid", out_valid, 1);
      chk("stream_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stream_last_valid", out_valid, 1);
    @(posedge clk); #1;
    chk("stream_drop_valid", out_valid, 0);
    chk("stream_count", npop - p0, 5);

    // Reset in the middle of a multiply
    drive(3'd7, 8'h0D, 8'h0B);
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_outputs", {out_valid, alu_out, carry, overflow, zero, negative}, 0);
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 0);
    chk("abort_in_ready", in_ready, 1);
    run_op(3'd0, 8'h21, 8'h42, 1, "add_after_abort");

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
